alu_mc: RTL and testbench



---
 rtl/alu_mc_pkg.sv | 37 +++
 rtl/alu_mc_if.sv | 27 ++
 rtl/alu_mc_iter_muldiv.sv | 94 +++++++++
 rtl/alu_mc.sv | 123 ++++++++++++
 tb/tb_alu_mc.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - opcode encodings (OP_ADD .. OP_REMU)
//   - controller state encoding
//   - flag bit positions within f
//   - is_muldiv(): decodes the opcodes served by the iterative unit
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ADDV  = 4'b0010;
    localparam logic [3:0] OP_SUBV  = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int F_CARRY = 2;
    localparam int F_OVF   = 1;
    localparam int F_ZERO  = 0;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle of the multi-cycle ALU.
//   in_valid/in_ready  : operand handshake (in1, in2, opcode s)
//   out_valid/out_ready: result handshake (out, flags f)
// Modports: master = operand producer / result consumer, slave = the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [2:0]       f;

    modport master (
        output in_valid, in1, in2, s, out_ready,
        input  in_ready, out_valid, out, f
    );

    modport slave (
        input  in_valid, in1, in2, s, out_ready,
        output in_ready, out_valid, out, f
    );
endinterface

// File: rtl/alu_mc_iter_muldiv.sv
// alu_iter_muldiv: iterative unsigned multiply / restoring divide, one step
// per cycle for WIDTH cycles. Compiled only when ALU_MULDIV_EN is defined.
//   clk, rst  : clock, synchronous active-high reset
//   start     : latch operands and begin (a = multiplier/dividend, b = multiplicand/divisor)
//   is_div    : 1 = divide, 0 = multiply
//   sel_hi    : 1 = upper half (mulhu / remainder), 0 = lower half (mul / quotient)
//   done      : high in the cycle of the final step; result is valid then
//   result    : outcome of the final step
//   div_zero  : divide with b == 0
`ifdef ALU_MULDIV_EN
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             sel_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             active;
    logic [CW-1:0]    cnt;
    logic             div_r;
    logic             sel_r;
    // hi:lo is the product accumulator for mul, remainder:quotient for div.
    logic [WIDTH-1:0] hi, lo, opb;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [WIDTH:0]   add_sum, shifted, sub_val;
    logic             ge;

    assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    assign shifted = {hi, lo[WIDTH-1]};
    assign sub_val = shifted - {1'b0, opb};
    assign ge      = (shifted >= {1'b0, opb});

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt_hi = hi;
        nxt_lo = lo;
        if (div_r) begin
            // With a zero divisor every step subtracts nothing: the quotient fills
            // with ones and the dividend shifts whole into the remainder.
            nxt_hi = ge ? sub_val[WIDTH-1:0] : shifted[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = add_sum[WIDTH:1];
            nxt_lo = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

    assign done     = active && (cnt == CW'(WIDTH - 1));
    assign result   = sel_r ? nxt_hi : nxt_lo;
    assign div_zero = div_r && (opb == '0);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // NOTE: datapath registers are not reset; they are always loaded by start before being read.
    always_ff @(posedge clk) begin
        if (start) begin
            hi    <= '0;
            lo    <= a;
            opb   <= b;
            div_r <= is_div;
            sel_r <= sel_hi;
        end else if (active) begin
            hi <= nxt_hi;
            lo <= nxt_lo;
        end
    end

endmodule
`endif

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake on both sides and
// registered result/flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_mc_if.slave (in_valid/in_ready/in1/in2/s,
//              out_valid/out_ready/out/f)
// Optional feature: define ALU_MULDIV_EN to enable opcodes 1010-1101 through
// the iterative unit; otherwise they return out=0, f=001 in one cycle.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_mc_if.slave      bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] out_r;
    logic [2:0]       f_r;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] c_res;
    logic [2:0]       c_f;
    logic             go_busy;

    assign a   = bus.in1;
    assign b   = bus.in2;
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out       = out_r;
    assign bus.f         = f_r;

    always_comb begin
        c_res = '0;
        c_f   = '0;
        case (bus.s)
            OP_ADD:  begin c_res = sum[WIDTH-1:0]; c_f[F_CARRY] = sum[WIDTH]; end
            OP_SUB:  begin c_res = dif[WIDTH-1:0]; c_f[F_CARRY] = dif[WIDTH]; end
            OP_ADDV: begin
                c_res      = sum[WIDTH-1:0];
                c_f[F_OVF] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBV: begin
                c_res      = dif[WIDTH-1:0];
                c_f[F_OVF] = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  c_res = a & b;
            OP_OR:   c_res = a | b;
            OP_XOR:  c_res = a ^ b;
            OP_NOR:  c_res = ~(a | b);
            OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: c_res = '0;
        endcase
        c_f[F_ZERO] = (c_res == '0);
    end

`ifdef ALU_MULDIV_EN
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             md_div_zero;

    assign go_busy = is_muldiv(bus.s);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (bus.in_valid && (state == S_IDLE) && go_busy),
        .is_div   (bus.s[2]),
        .sel_hi   (bus.s[0]),
        .a        (a),
        .b        (b),
        .done     (md_done),
        .result   (md_result),
        .div_zero (md_div_zero)
    );
`else
    assign go_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            out_r <= '0;
            f_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (go_busy) begin
                            state <= S_BUSY;
                        end else begin
                            out_r <= c_res;
                            f_r   <= c_f;
                            state <= S_DONE;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                S_BUSY: begin
                    if (md_done) begin
                        out_r <= md_result;
                        f_r   <= {1'b0, md_div_zero, (md_result == '0)};
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic [2:0]   f;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected values for opcodes that depend on the mul/div build option.
    function automatic logic [W-1:0] md_out(input logic [W-1:0] v);
        return MD ? v : '0;
    endfunction
    function automatic logic [2:0] md_f(input logic [2:0] v);
        return MD ? v : 3'b001;
    endfunction
    function automatic int md_lat();
        return MD ? W + 1 : 1;
    endfunction

    // Monitor: compares each result as it is released.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got out=%0h f=%0b with nothing expected", bus.out, bus.f);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_out"}, bus.out, e.out);
                    check({e.name, "_f"}, bus.f, e.f);
                end
            end
        end
    end

    // Issue one operation (inputs are driven 1 time unit after a rising edge).
    task automatic run(input string name, input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eo, input logic [2:0] ef,
                       input int lat, input int hold);
        int   n;
        logic rdy_seen;
        sb.push_back('{name, eo, ef});
        bus.s        = op;
        bus.in1      = x;
        bus.in2      = y;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // Garbage on the inputs after accept must be ignored.
        bus.in_valid = 1'b1;
        bus.in1      = ~x;
        bus.in2      = ~y;
        bus.s        = OP_NOR;
        n        = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && n < 200) begin
            rdy_seen |= bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check({name, "_latency"}, n, lat);
        check({name, "_ready_while_busy"}, rdy_seen, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, bus.out_valid, 1'b1);
            check({name, "_hold_ready"}, bus.in_ready, 1'b0);
            check({name, "_hold_out"}, bus.out, eo);
            check({name, "_hold_f"}, bus.f, ef);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_ready_after"}, bus.in_ready, 1'b1);
        check({name, "_valid_after"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.s         = OP_ADD;
        bus.in1       = '0;
        bus.in2       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out", bus.out, 0);
        check("reset_f", bus.f, 3'b000);
        rst = 1'b0;

        run("add_carry", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b101, 1, 0);
        run("addv_ovf",  OP_ADDV, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b010, 1, 0);
        run("sltu",      OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b001, 1, 0);
        run("slt",       OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 3'b000, 1, 0);
        run("sub_borrow",OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 3'b100, 1, 0);
        run("subv_ovf",  OP_SUBV, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b010, 1, 0);
        run("and",       OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 3'b000, 1, 0);
        run("or",        OP_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 3'b000, 1, 0);
        run("xor",       OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 3'b000, 1, 0);
        run("nor_ones",  OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 3'b000, 1, 0);
        run("nor_zero",  OP_NOR,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 3'b001, 1, 0);
        run("op1110",    4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 3'b001, 1, 0);
        run("op1111",    4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 3'b001, 1, 0);

        run("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md_out(32'hFFFF_FFFE), md_f(3'b000), md_lat(), 0);
        run("mul",   OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, md_out(32'h0000_0001), md_f(3'b000), md_lat(), 0);
        run("mul_small", OP_MUL, 32'd1234, 32'd5678, md_out(32'd7006652), md_f(3'b000), md_lat(), 0);
        run("divu",  OP_DIVU, 32'd100, 32'd7, md_out(32'd14), md_f(3'b000), md_lat(), 5);
        run("remu",  OP_REMU, 32'd100, 32'd7, md_out(32'd2),  md_f(3'b000), md_lat(), 0);
        run("divu_z",OP_DIVU, 32'd5,   32'd0, md_out(32'hFFFF_FFFF), md_f(3'b010), md_lat(), 0);
        run("remu_z",OP_REMU, 32'd5,   32'd0, md_out(32'd5), md_f(3'b010), md_lat(), 0);
        run("remu_0",OP_REMU, 32'd7,   32'd7, md_out(32'd0), md_f(3'b001), md_lat(), 0);

        // Reset part-way through a multiply: result discarded, reset values restored.
        bus.s        = OP_MUL;
        bus.in1      = 32'hFFFF_FFFF;
        bus.in2      = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("pre_rst_valid", bus.out_valid, !MD);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out", bus.out, 0);
        check("rst_f", bus.f, 3'b000);

        run("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 3'b000, 1, 0);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
